// File: rtl/best_fir_s_axi_regs_if.sv
// AXI4-Lite bundle for the best_fir control port; master drives requests, slave responds.
interface best_fir_s_axi_regs_if #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) ();
  logic [AddrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [AddrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/best_fir_s_axi_regs.sv
// AXI4-Lite register bank for best_fir: one outstanding write and one outstanding read,
// SLVERR beyond the map, per-register commit pulses toward the datapath.
module best_fir_s_axi_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_aresetn,
  best_fir_s_axi_regs_if.slave               s00_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned StrbW = DW / 8;
  localparam int unsigned IdxW  = C_S_AXI_ADDR_WIDTH - 2;

  logic            rst_done_q;
  logic            aw_full_q, aw_full_d;
  logic [IdxW-1:0] aw_idx_q, aw_idx_d;
  logic            w_full_q, w_full_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [StrbW-1:0] w_strb_q, w_strb_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   regs_q [NUM_REGS];
  logic [DW-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, aw_ok, ar_ok;
  logic [IdxW-1:0] ar_idx;
  logic [DW-1:0]   rd_val;
  logic            unused_bits;

  assign s00_axi.awready = rst_done_q & ~aw_full_q & ~bvalid_q;
  assign s00_axi.wready  = rst_done_q & ~w_full_q & ~bvalid_q;
  assign s00_axi.arready = rst_done_q & ~rvalid_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;
  assign reg_wr_pulse    = pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[DW*i +: DW] = regs_q[i];
  end

  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                         s00_axi.araddr[1:0]};

  assign aw_hs  = s00_axi.awvalid & s00_axi.awready;
  assign w_hs   = s00_axi.wvalid & s00_axi.wready;
  assign ar_hs  = s00_axi.arvalid & s00_axi.arready;
  assign b_hs   = bvalid_q & s00_axi.bready;
  assign r_hs   = rvalid_q & s00_axi.rready;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_ok  = 32'(aw_idx_q) < NUM_REGS;
  assign ar_ok  = 32'(ar_idx) < NUM_REGS;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == i) rd_val = regs_q[i];
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi.wdata;
      w_strb_d = s00_axi.wstrb;
    end

    // Commit and B handshake are exclusive: commit needs bvalid low, handshake needs it high.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? 2'b00 : 2'b10;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (aw_ok && 32'(aw_idx_q) == i) begin
          pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end

    // Reads sample regs_q, so a same-edge commit to the same register is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? rd_val : '0;
      rresp_d  = ar_ok ? 2'b00 : 2'b10;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      regs_q     <= '{default: '0};
      pulse_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
    end
  end
endmodule

// File: doc/best_fir_s_axi_regs.md
Name: best_fir_s_axi_regs

Overview:
AXI4-Lite slave (responder) register bank for the best_fir IP. It is the peripheral end of the S00_AXI interface that the AXI VIP master drives.
- Accepts single-beat writes and reads into NUM_REGS 32-bit control registers.
- Exposes the register contents and per-register write pulses to the FIR datapath.
- Returns SLVERR for addresses beyond the register map.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[ADDR_WIDTH-1:2]
NUM_REGS, 4, implemented registers at 0x00, 0x04, ... up to (NUM_REGS-1)*4

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  00 OKAY, 10 SLVERR
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  00 OKAY, 10 SLVERR
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*32  register i at bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on bit i when register i is committed

Behaviour:
Clock and reset:
- One clock, s00_axi_aclk.
- Reset s00_axi_aresetn is asynchronous, active-low.

Reset state, and on any aresetn assertion including mid-transaction:
- All registers 0.
- awready, wready, arready, bvalid, rvalid all 0; bresp, rresp, rdata 0; reg_wr_pulse 0.
- aw_full, w_full and rst_done cleared; any in-flight transaction is dropped with no response.
- rst_done is set on the first clock edge after deassertion. No ready is high before then.

Write channel:
- AW and W are buffered independently in aw_full and w_full holding registers, in either order or in the same cycle.
- awready = rst_done & ~aw_full & ~bvalid. wready = rst_done & ~w_full & ~bvalid.
- Commit occurs on the edge where aw_full & w_full & ~bvalid. At that edge:
  - Write the held data into the addressed register, byte-masked by the held wstrb (a strobe bit of 0 keeps that byte).
  - Pulse reg_wr_pulse[idx] for exactly that one cycle.
  - Set bvalid; bresp = 00.
  - Clear aw_full and w_full.
- Latency: AW and W handshaking on edge T gives the register update and bvalid visible after edge T+1.
- Out of range (idx >= NUM_REGS): no register change, no pulse, bresp = 10.
- bvalid and bresp are held stable until the bready handshake, then bvalid = 0.
- No new AW or W is accepted while bvalid = 1. This gives one outstanding write.

Read channel:
- arready = rst_done & ~rvalid.
- On an AR handshake at edge T:
  - rdata = register[idx], or 0 if out of range.
  - rresp = 00, or 10 if out of range.
  - rvalid = 1, visible after T.
- rdata, rresp and rvalid are held until the rready handshake. One outstanding read.
- Read and write paths are independent and may complete in the same cycle.
- If a write commit and an AR handshake occur on the same edge to the same register, the read returns the pre-write value.

General:
- Address bits [1:0] are ignored.
- reg_out is driven directly from the register flops.

Test Plan:
1. Reset 200 ns; write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C with wstrb=F; read back -> rdata 1, 2, 3, 4. All bresp and rresp are 00. reg_out = {4, 3, 2, 1}. reg_wr_pulse pulses bits 0..3 once each.
2. Present W (0xDEADBEEF) 3 cycles before AW (0x08) -> wready drops after the W handshake; commit occurs one cycle after the AW handshake; exactly one bvalid; reg2 = 0xDEADBEEF.
3. reg0 = 0x00000001; write 0xAABBCCDD with wstrb=0010 -> reg0 = 0x0000CC01.
4. Write 0x12345678 to 0x10 -> bresp = 10, all registers unchanged, no pulse. Read 0x14 -> rdata = 0, rresp = 10.
5. Hold bready low 5 cycles after a write -> bvalid and bresp stable, awready and wready low, a second AW is not accepted until the B handshake. Hold rready low -> rdata stable and arready low.
6. Assert aresetn low with AW held and W pending -> all outputs 0 immediately (asynchronous). After release, no stale bvalid; registers read 0.
